// File: rtl/rc4_xor_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : rc4_xor_stream_if
// Description : Keystream, data-in/data-out and status bundle for rc4_xor_stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface rc4_xor_stream_if;
    logic        ks_init_done;
    logic [7:0]  ks_byte;
    logic        ks_valid;
    logic        ks_run;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_last;
    logic        din_ready;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_last;
    logic        dout_ready;
    logic [15:0] byte_count;
    logic        ks_overflow;

    modport master (
        output ks_init_done, ks_byte, ks_valid, din, din_valid, din_last, dout_ready,
        input  ks_run, din_ready, dout, dout_valid, dout_last, byte_count, ks_overflow
    );

    modport slave (
        input  ks_init_done, ks_byte, ks_valid, din, din_valid, din_last, dout_ready,
        output ks_run, din_ready, dout, dout_valid, dout_last, byte_count, ks_overflow
    );
endinterface
`default_nettype wire

// File: rtl/rc4_xor_stream.sv
`default_nettype none
// ============================================================================
// Module      : rc4_xor_stream
// Description : Buffers an external RC4 keystream in a small FIFO and XORs it
//               onto a byte stream with a one-cycle registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_xor_stream #(
    parameter int KS_DEPTH = 4,
    parameter int DROP_N   = 0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    rc4_xor_stream_if.slave bus
);

    localparam int                c_PTR_W     = $clog2(KS_DEPTH);
    localparam logic [c_PTR_W:0]  c_DEPTH     = (c_PTR_W + 1)'(KS_DEPTH);
    localparam logic [9:0]        c_DROP_LAST = (DROP_N == 0) ? 10'd0 : 10'(DROP_N - 1);

    localparam logic [1:0] S_WAIT_INIT = 2'd0;
    localparam logic [1:0] S_DROP      = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [9:0]         r_drop_cnt;

    logic [7:0]         r_mem [KS_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;

    logic [7:0]         r_dout;
    logic               r_dout_valid;
    logic               r_dout_last;
    logic [15:0]        r_byte_count;

    logic               w_ks_run;
    logic               w_din_ready;
    logic               w_flush;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_lost;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_WAIT_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT_INIT: begin
                if (bus.ks_init_done) begin
                    w_state_next = (DROP_N == 0) ? S_RUN : S_DROP;
                end
            end
            S_DROP: begin
                if (!bus.ks_init_done) begin
                    w_state_next = S_WAIT_INIT;
                end else if (bus.ks_valid && (r_drop_cnt == c_DROP_LAST)) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.ks_init_done) begin
                    w_state_next = S_WAIT_INIT;
                end
            end
            default: w_state_next = S_WAIT_INIT;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        w_ks_run    = (r_state == S_DROP) || (r_state == S_RUN);
        w_din_ready = (r_state == S_RUN) && !w_empty && (!r_dout_valid || bus.dout_ready);
    end

    // Losing init_done flushes in the same cycle, so no stale keystream survives a re-key.
    assign w_flush = (r_state == S_WAIT_INIT) || !bus.ks_init_done;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_pop   = bus.din_valid && w_din_ready;
    assign w_push  = (r_state == S_RUN) && !w_flush && bus.ks_valid && (!w_full || w_pop);
    assign w_lost  = (r_state == S_RUN) && !w_flush && bus.ks_valid && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if ((r_state == S_DROP) && bus.ks_init_done) begin
            if (bus.ks_valid) begin
                r_drop_cnt <= (r_drop_cnt == c_DROP_LAST) ? 10'd0 : r_drop_cnt + 10'd1;
            end
        end else begin
            r_drop_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.ks_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
            if (w_lost) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output stage survives a flush: a pending word is only cleared by transfer or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_byte_count <= 16'h0000;
        end else if (w_pop) begin
            r_dout       <= bus.din ^ r_mem[r_rd_ptr];
            r_dout_valid <= 1'b1;
            r_dout_last  <= bus.din_last;
            r_byte_count <= bus.din_last ? 16'h0000 : r_byte_count + 16'h0001;
        end else if (bus.dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign bus.ks_run      = w_ks_run;
    assign bus.din_ready   = w_din_ready;
    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.dout_last   = r_dout_last;
    assign bus.byte_count  = r_byte_count;
    assign bus.ks_overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/rc4_xor_stream.md
RC4_XOR_STREAM -- requirements
Module: rc4_xor_stream

Interface
REQ-001 SHALL have parameter KS_DEPTH, default 4, keystream FIFO depth in bytes (power of 2, 2..16).
REQ-002 SHALL have parameter DROP_N, default 0, number of keystream bytes discarded after generator init (0..1023).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ks_init_done  input  1  generator key schedule complete.
REQ-006 SHALL have port ks_byte  input  8  keystream byte from generator.
REQ-007 SHALL have port ks_valid  input  1  keystream strobe; each high cycle is one new byte.
REQ-008 SHALL have port ks_run  output  1  start/run request to generator.
REQ-009 SHALL have port din  input  8  plaintext or ciphertext byte.
REQ-010 SHALL have port din_valid  input  1  din qualifier.
REQ-011 SHALL have port din_last  input  1  din is last byte of frame.
REQ-012 SHALL have port din_ready  output  1  din accepted this cycle when high with din_valid.
REQ-013 SHALL have port dout  output  8  din XOR keystream.
REQ-014 SHALL have port dout_valid  output  1  dout qualifier.
REQ-015 SHALL have port dout_last  input-aligned  output  1  last byte of frame.
REQ-016 SHALL have port dout_ready  input  1  downstream accepts dout.
REQ-017 SHALL have port byte_count  output  16  bytes accepted in current frame.
REQ-018 SHALL have port ks_overflow  output  1  sticky: keystream byte lost.

Function
REQ-019 SHALL implement states WAIT_INIT, DROP, RUN.
REQ-020 WAIT_INIT: ks_run low, FIFO held empty; go to DROP when ks_init_done high (directly to RUN if DROP_N=0).
REQ-021 DROP: ks_run high; count ks_valid strobes, discard bytes; after DROP_N-th strobe go to RUN; no FIFO writes.
REQ-022 RUN: ks_run high; each ks_valid strobe writes ks_byte to FIFO tail.
REQ-023 FIFO full and ks_valid with no pop same cycle: byte dropped, ks_overflow set, remains set until reset.
REQ-024 Push and pop same cycle when full: both performed, occupancy unchanged, no overflow.
REQ-025 din_ready = state RUN AND FIFO not empty AND (dout_valid low OR dout_ready high); combinational.
REQ-026 Accepted din: pop FIFO head; next cycle dout = din XOR head, dout_valid high, dout_last = din_last (latency 1).
REQ-027 dout, dout_last SHALL hold stable while dout_valid high and dout_ready low.
REQ-028 dout_valid SHALL clear after transfer with no new accept same cycle; back-to-back transfers at one byte/cycle SHALL be supported while FIFO nonempty.
REQ-029 byte_count increments per accepted byte, wraps 0xFFFF->0, returns to 0 the cycle after an accepted din_last byte.
REQ-030 FIFO pointers wrap modulo KS_DEPTH; occupancy 0..KS_DEPTH.
REQ-031 ks_init_done falling in DROP or RUN: go to WAIT_INIT, flush FIFO, clear drop counter; pending dout word retained until transferred.
REQ-032 Keystream bytes consumed strictly in arrival order; no byte reused.

Reset
REQ-033 On rst: state WAIT_INIT, FIFO empty, drop counter 0, ks_run 0, din_ready 0, dout 0x00, dout_valid 0, dout_last 0, byte_count 0, ks_overflow 0.
REQ-034 rst asserted mid-frame SHALL abort immediately; pending dout discarded.

Verification
REQ-035 DROP_N=0; init_done=1; ks strobes 0xA5,0x3C every 2 cycles; din 0xFF,0x00 (last on 2nd) -> dout 0x5A,0x3C, dout_last on 2nd, byte_count 0 afterwards.
REQ-036 DROP_N=3; strobes 0x11,0x22,0x33,0x44; din 0x00 -> dout 0x44; first three never appear.
REQ-037 KS_DEPTH=4; 5 strobes, din_valid low -> ks_overflow=1 after 5th; FIFO holds first 4 bytes.
REQ-038 dout_ready low 3 cycles with dout_valid high -> dout stable, din_ready 0; release -> data transferred once.
REQ-039 ks_init_done dropped in RUN with 2 FIFO bytes -> WAIT_INIT, ks_run 0, din_ready 0; reassert -> next din uses new keystream only.
REQ-040 rst pulse mid-frame at byte_count 5 -> all outputs at REQ-033 values same cycle (asynchronous).
